systolic_array_4x4: RTL and testbench

- 4x4 output-stationary systolic array that consumes the four A-column and four B-row operand words staged by the TPU control FSM.
- Computes one 4x4x4 int8 partial matrix product into 32-bit accumulators.
- Presents the product as four 128-bit C rows and raises done.
- Sits directly downstream of the TPU control FSM, which sequences K-offset passes and accumulates returned C rows across passes.

---
 rtl/systolic_array_4x4.sv | 173 +++++++++++++++++
 tb/tb_systolic_array_4x4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary int8 systolic array with int32 accumulators.
// Operands are latched at start, skewed into the array, and C rows are held once done.
module systolic_array_4x4 #(
  parameter int unsigned DATA_BITS  = 32,
  parameter int unsigned DATAC_BITS = 128,
  parameter int unsigned LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sa_rst_n,
  input  logic [DATA_BITS-1:0]  local_buffer_A0,
  input  logic [DATA_BITS-1:0]  local_buffer_A1,
  input  logic [DATA_BITS-1:0]  local_buffer_A2,
  input  logic [DATA_BITS-1:0]  local_buffer_A3,
  input  logic [DATA_BITS-1:0]  local_buffer_B0,
  input  logic [DATA_BITS-1:0]  local_buffer_B1,
  input  logic [DATA_BITS-1:0]  local_buffer_B2,
  input  logic [DATA_BITS-1:0]  local_buffer_B3,
  output logic                  done,
  output logic [DATAC_BITS-1:0] local_buffer_C0,
  output logic [DATAC_BITS-1:0] local_buffer_C1,
  output logic [DATAC_BITS-1:0] local_buffer_C2,
  output logic [DATAC_BITS-1:0] local_buffer_C3,
  output logic [1:0]            state_SA_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ACC_W = 32;
  localparam logic [CNT_W-1:0] LAST_MAC = 4'd11;

  logic [1:0]           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] a_lat [LANES];
  logic [DATA_BITS-1:0] b_lat [LANES];
  logic [7:0]           a_left [LANES];
  logic [7:0]           b_top  [LANES];
  logic [7:0]           a_inj  [LANES];
  logic [7:0]           b_inj  [LANES];
  logic [7:0]           a_pipe [LANES][LANES-1];
  logic [7:0]           b_pipe [LANES-1][LANES];
  logic [7:0]           a_in   [LANES][LANES];
  logic [7:0]           b_in   [LANES][LANES];
  logic signed [15:0]   prod   [LANES][LANES];
  logic [ACC_W-1:0]     acc    [LANES][LANES];
  logic [ACC_W-1:0]     acc_nxt[LANES][LANES];
  logic [DATAC_BITS-1:0] c_row [LANES];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
    end
  end

  // Next-state logic; sa_rst_n low forces IDLE from any state
  always_comb begin
    state_nxt = state;
    if (!sa_rst_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = LOAD;
        LOAD:    state_nxt = RUN;
        RUN:     if (cnt == LAST_MAC) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Skewed injection: row r / column n gets operand index k when cnt == k + r (or k + n)
  always_comb begin
    a_inj = '{default: '0};
    b_inj = '{default: '0};
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (cnt == CNT_W'(k + i)) begin
          a_inj[i] = a_lat[k][8*(LANES-1-i) +: 8];
          b_inj[i] = b_lat[k][8*(LANES-1-i) +: 8];
        end
      end
    end
  end

  // PE operand routing and MAC
  always_comb begin
    a_in    = '{default: '0};
    b_in    = '{default: '0};
    prod    = '{default: '0};
    acc_nxt = '{default: '0};
    for (int unsigned r = 0; r < LANES; r++) begin
      a_in[r][0] = a_left[r];
      b_in[0][r] = b_top[r];
      for (int unsigned n = 1; n < LANES; n++) begin
        a_in[r][n] = a_pipe[r][n-1];
        b_in[n][r] = b_pipe[n-1][r];
      end
    end
    for (int unsigned r = 0; r < LANES; r++) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        prod[r][n]    = $signed(a_in[r][n]) * $signed(b_in[r][n]);
        acc_nxt[r][n] = acc[r][n] + {{(ACC_W-16){prod[r][n][15]}}, prod[r][n]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_lat  <= '{default: '0};
      b_lat  <= '{default: '0};
      a_left <= '{default: '0};
      b_top  <= '{default: '0};
      a_pipe <= '{default: '0};
      b_pipe <= '{default: '0};
      acc    <= '{default: '0};
    end else if (!sa_rst_n) begin
      cnt    <= '0;
      a_left <= '{default: '0};
      b_top  <= '{default: '0};
      a_pipe <= '{default: '0};
      b_pipe <= '{default: '0};
      acc    <= '{default: '0};
    end else if (state == IDLE) begin
      cnt      <= '0;
      a_lat[0] <= local_buffer_A0;
      a_lat[1] <= local_buffer_A1;
      a_lat[2] <= local_buffer_A2;
      a_lat[3] <= local_buffer_A3;
      b_lat[0] <= local_buffer_B0;
      b_lat[1] <= local_buffer_B1;
      b_lat[2] <= local_buffer_B2;
      b_lat[3] <= local_buffer_B3;
    end else if (state == LOAD || state == RUN) begin
      cnt    <= cnt + CNT_W'(1);
      a_left <= a_inj;
      b_top  <= b_inj;
      acc    <= acc_nxt;
      for (int unsigned r = 0; r < LANES; r++) begin
        for (int unsigned n = 0; n < LANES - 1; n++) begin
          a_pipe[r][n] <= a_in[r][n];
          b_pipe[n][r] <= b_in[n][r];
        end
      end
    end
  end

  // C rows are combinational views of the accumulators; lane 0 in the top word
  always_comb begin
    c_row = '{default: '0};
    for (int unsigned r = 0; r < LANES; r++) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        c_row[r][ACC_W*(LANES-1-n) +: ACC_W] = acc[r][n];
      end
    end
  end

  assign local_buffer_C0 = c_row[0];
  assign local_buffer_C1 = c_row[1];
  assign local_buffer_C2 = c_row[2];
  assign local_buffer_C3 = c_row[3];
  assign state_SA_o      = state;

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Self-checking bench for systolic_array_4x4: directed table, random passes against
// a plain matrix-product model, abort/reset corner cases and result hold.
module tb_systolic_array_4x4;

  typedef struct {
    logic [3:0][31:0]  a;
    logic [3:0][31:0]  b;
    logic [3:0][127:0] c;
  } vec_t;

  localparam int unsigned NVEC = 23;

  logic clk = 1'b0;
  logic rst_n, sa_rst_n;
  logic [3:0][31:0] a_drv, b_drv;
  logic done;
  logic [127:0] c0, c1, c2, c3;
  logic [1:0] state_sa;

  int total = 0;
  int bad = 0;
  vec_t tab [NVEC];

  systolic_array_4x4 dut (
    .clk(clk), .rst_n(rst_n), .sa_rst_n(sa_rst_n),
    .local_buffer_A0(a_drv[0]), .local_buffer_A1(a_drv[1]),
    .local_buffer_A2(a_drv[2]), .local_buffer_A3(a_drv[3]),
    .local_buffer_B0(b_drv[0]), .local_buffer_B1(b_drv[1]),
    .local_buffer_B2(b_drv[2]), .local_buffer_B3(b_drv[3]),
    .done(done),
    .local_buffer_C0(c0), .local_buffer_C1(c1),
    .local_buffer_C2(c2), .local_buffer_C3(c3),
    .state_SA_o(state_sa)
  );

  always #5 clk = ~clk;

  // Reference: C[r][n] = sum_k A[r][k]*B[k][n], signed int8, wrapping int32
  function automatic logic [3:0][127:0] model(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
    logic [3:0][127:0] c;
    byte av, bv;
    int sum;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) begin
        sum = 0;
        for (int k = 0; k < 4; k++) begin
          av = a[k][8*(3-r) +: 8];
          bv = b[k][8*(3-n) +: 8];
          sum += int'(av) * int'(bv);
        end
        c[r][32*(3-n) +: 32] = sum;
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_c(input string name, input logic [3:0][127:0] exp);
    chk({name, "_c0"}, c0, exp[0]);
    chk({name, "_c1"}, c1, exp[1]);
    chk({name, "_c2"}, c2, exp[2]);
    chk({name, "_c3"}, c3, exp[3]);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_state"}, 128'(state_sa), 128'd0);
    chk({name, "_done"}, 128'(done), 128'd0);
    chk_c(name, '0);
  endtask

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      a_drv[i] = $urandom;
      b_drv[i] = $urandom;
    end
  endtask

  task automatic clear_tick(input string name);
    sa_rst_n = 1'b0;
    tick();
    chk_idle(name);
  endtask

  // Full pass from IDLE; leaves the DUT in DONE with sa_rst_n high
  task automatic run_pass(input vec_t v, input string name);
    a_drv = v.a;
    b_drv = v.b;
    sa_rst_n = 1'b1;
    tick();
    chk({name, "_load"}, 128'(state_sa), 128'd1);
    scramble();
    repeat (11) tick();
    chk({name, "_done_e11"}, 128'(done), 128'd0);
    tick();
    chk({name, "_done_e12"}, 128'(done), 128'd1);
    chk({name, "_state_e12"}, 128'(state_sa), 128'd3);
    chk_c(name, v.c);
  endtask

  initial begin
    vec_t v;
    logic [3:0][127:0] held;

    tab[0].a = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    tab[0].b = '{32'h04050607, 32'h03040506, 32'h02030405, 32'h01020304};
    tab[0].c = '{128'h00000004_00000005_00000006_00000007,
                 128'h00000003_00000004_00000005_00000006,
                 128'h00000002_00000003_00000004_00000005,
                 128'h00000001_00000002_00000003_00000004};
    tab[1].a = '{default: 32'h80808080};
    tab[1].b = '{default: 32'h80808080};
    tab[1].c = '{default: {4{32'h00010000}}};
    tab[2].a = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tab[2].b = '{32'h0, 32'h0, 32'h02020202, 32'h02020202};
    tab[2].c = '{default: {4{32'hFFFFFFFC}}};
    for (int i = 3; i < NVEC; i++) begin
      for (int k = 0; k < 4; k++) begin
        tab[i].a[k] = $urandom;
        tab[i].b[k] = $urandom;
      end
      tab[i].c = model(tab[i].a, tab[i].b);
    end

    rst_n = 1'b0;
    sa_rst_n = 1'b0;
    a_drv = '0;
    b_drv = '0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    for (int i = 0; i < NVEC; i++) begin
      run_pass(tab[i], $sformatf("vec%0d", i));
      clear_tick($sformatf("clr%0d", i));
    end

    // Abort mid-run, then restart with different operands
    a_drv = tab[1].a;
    b_drv = tab[1].b;
    sa_rst_n = 1'b1;
    repeat (7) tick();
    a_drv = tab[0].a;
    b_drv = tab[0].b;
    clear_tick("abort");
    run_pass(tab[0], "restart");

    // Result held in DONE while inputs toggle
    held = tab[0].c;
    for (int i = 0; i < 20; i++) begin
      scramble();
      tick();
      chk("hold_done", 128'(done), 128'd1);
      chk_c("hold", held);
    end
    clear_tick("hold_clr");

    // Asynchronous reset between edges mid-run
    v = tab[1];
    a_drv = v.a;
    b_drv = v.b;
    sa_rst_n = 1'b1;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sa_rst_n = 1'b0;
    tick();
    chk_idle("async_rel");
    run_pass(tab[2], "after_async");
    clear_tick("final_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
